// File: rtl/alu_calc_core_if.sv
// Button/operand/result bundle between the board top level and alu_calc_core.
// master drives buttons and controls; slave is the calculator core.
interface alu_calc_core_if #(
  parameter int unsigned W = 4
);
  logic           btn_a;
  logic           btn_b;
  logic           btn_exec;
  logic           dir;
  logic [2:0]     op;
  logic           acc_mode;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] res;
  logic           carry;
  logic           ovf;
  logic           zero;
  logic           busy;
  logic           valid;

  modport master (
    output btn_a, btn_b, btn_exec, dir, op, acc_mode,
    input  a_q, b_q, res, carry, ovf, zero, busy, valid
  );

  modport slave (
    input  btn_a, btn_b, btn_exec, dir, op, acc_mode,
    output a_q, b_q, res, carry, ovf, zero, busy, valid
  );
endinterface

// File: rtl/alu_calc_core.sv
// Calculator core: button-stepped operand registers, 8-op ALU with a
// sequential shift-add multiplier, registered result/flags, accumulator mode.
module alu_calc_core #(
  parameter int unsigned W = 4
) (
  input logic           clk,
  input logic           rstn,
  alu_calc_core_if.slave io
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_e;

  localparam int unsigned CW = $clog2(W) + 1;

  state_e         state, state_nx;
  logic           prev_a, prev_b, prev_x;
  logic           press_a, press_b, press_x;
  logic           busy;
  logic [W-1:0]   a_q, b_q, a_l, b_l, mplier;
  op_e            op_l;
  logic [2*W-1:0] mcand, prod, res_q, res_nx;
  logic [CW-1:0]  cnt;
  logic           carry_q, ovf_q, zero_q, valid_q;
  logic           carry_nx, ovf_nx;
  logic [W:0]     sum;
  logic [W-1:0]   diff;

  assign press_a = io.btn_a & ~prev_a;
  assign press_b = io.btn_b & ~prev_b;
  assign press_x = io.btn_exec & ~prev_x;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (press_x) state_nx = (op_e'(io.op) == OP_MUL) ? MUL : DONE;
      MUL:  if (cnt == CW'(W - 1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Edge-detect history keeps tracking while busy so held buttons never re-fire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_a <= 1'b0;
      prev_b <= 1'b0;
      prev_x <= 1'b0;
    end else begin
      prev_a <= io.btn_a;
      prev_b <= io.btn_b;
      prev_x <= io.btn_exec;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (state == DONE && io.acc_mode) a_q <= res_nx[W-1:0];
      else if (!busy && press_a)        a_q <= io.dir ? a_q - W'(1) : a_q + W'(1);
      if (!busy && press_b)             b_q <= io.dir ? b_q - W'(1) : b_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_l    <= '0;
      b_l    <= '0;
      op_l   <= OP_ADD;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == IDLE && press_x) begin
      a_l    <= a_q;
      b_l    <= b_q;
      op_l   <= op_e'(io.op);
      mcand  <= {{W{1'b0}}, a_q};
      mplier <= b_q;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  always_comb begin
    sum      = {1'b0, a_l} + {1'b0, b_l};
    diff     = a_l - b_l;
    res_nx   = '0;
    carry_nx = 1'b0;
    ovf_nx   = 1'b0;
    case (op_l)
      OP_ADD: begin
        res_nx   = {{(W-1){1'b0}}, sum};
        carry_nx = sum[W];
        ovf_nx   = (a_l[W-1] == b_l[W-1]) && (sum[W-1] != a_l[W-1]);
      end
      OP_SUB: begin
        res_nx   = {{W{1'b0}}, diff};
        carry_nx = (a_l < b_l);
        ovf_nx   = (a_l[W-1] != b_l[W-1]) && (diff[W-1] != a_l[W-1]);
      end
      OP_AND: res_nx = {{W{1'b0}}, a_l & b_l};
      OP_OR:  res_nx = {{W{1'b0}}, a_l | b_l};
      OP_XOR: res_nx = {{W{1'b0}}, a_l ^ b_l};
      // A W-bit logical shift by B >= W already yields zero.
      OP_SHL: res_nx = {{W{1'b0}}, a_l << b_l};
      OP_SHR: res_nx = {{W{1'b0}}, a_l >> b_l};
      OP_MUL: begin
        res_nx   = prod;
        carry_nx = |prod[2*W-1:W];
      end
      default: res_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state == DONE);
      if (state == DONE) begin
        res_q   <= res_nx;
        carry_q <= carry_nx;
        ovf_q   <= ovf_nx;
        zero_q  <= (res_nx == '0);
      end
    end
  end

  assign io.a_q   = a_q;
  assign io.b_q   = b_q;
  assign io.res   = res_q;
  assign io.carry = carry_q;
  assign io.ovf   = ovf_q;
  assign io.zero  = zero_q;
  assign io.busy  = busy;
  assign io.valid = valid_q;
endmodule

// File: tb/tb_alu_calc_core.sv
// Randomised scoreboard bench for alu_calc_core against an integer-arithmetic
// reference model; a separate monitor pops expectations on every valid pulse.
module tb_alu_calc_core;
  localparam int W = 4;
  localparam int M = 1 << W;

  typedef struct {
    longint res;
    bit     c;
    bit     o;
    bit     z;
  } exp_t;

  logic clk;
  logic rstn;
  int   tests = 0;
  int   fails = 0;
  int   model_a = 0;
  int   model_b = 0;
  exp_t sb[$];

  alu_calc_core_if #(.W(W)) bus ();

  alu_calc_core #(.W(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  function automatic exp_t ref_model(input int op, input int a, input int b);
    exp_t e;
    int   s;
    e.res = 0; e.c = 0; e.o = 0;
    case (op)
      0: begin
        e.res = a + b;
        e.c   = (e.res >= M);
        s     = to_signed(a) + to_signed(b);
        e.o   = (s >= M / 2) || (s < -(M / 2));
      end
      1: begin
        e.res = (a - b + M) % M;
        e.c   = (a < b);
        s     = to_signed(a) - to_signed(b);
        e.o   = (s >= M / 2) || (s < -(M / 2));
      end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: e.res = (b >= W) ? 0 : (a << b) % M;
      6: e.res = (b >= W) ? 0 : (a >> b);
      default: begin
        e.res = a * b;
        e.c   = (e.res >= M);
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && bus.valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_valid: got completion res=%0d, expected none", bus.res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_res", bus.res, e.res);
        chk("sb_carry", bus.carry, e.c);
        chk("sb_ovf", bus.ovf, e.o);
        chk("sb_zero", bus.zero, e.z);
      end
    end
  end

  task automatic step(input bit sa, input bit sbt, input bit d);
    bus.dir   = d;
    bus.btn_a = sa;
    bus.btn_b = sbt;
    if (sa)  model_a = d ? (model_a + M - 1) % M : (model_a + 1) % M;
    if (sbt) model_b = d ? (model_b + M - 1) % M : (model_b + 1) % M;
    @(posedge clk); #1;
    bus.btn_a = 1'b0;
    bus.btn_b = 1'b0;
    @(posedge clk); #1;
    chk("step_a_q", bus.a_q, model_a);
    chk("step_b_q", bus.b_q, model_b);
  endtask

  task automatic set_ab(input int a, input int b);
    bit ga, gb;
    bus.dir = 1'b0;
    for (int i = 0; i < M && (model_a != a || model_b != b); i++) begin
      ga = (model_a != a);
      gb = (model_b != b);
      bus.btn_a = ga;
      bus.btn_b = gb;
      if (ga) model_a = (model_a + 1) % M;
      if (gb) model_b = (model_b + 1) % M;
      @(posedge clk); #1;
      bus.btn_a = 1'b0;
      bus.btn_b = 1'b0;
      @(posedge clk); #1;
    end
    chk("set_a_q", bus.a_q, a);
    chk("set_b_q", bus.b_q, b);
  endtask

  task automatic do_exec(input int op, input bit acc, input bit poke_b, input bit poke_a);
    exp_t e;
    int   lat;
    int   busy_n;
    e = ref_model(op, model_a, model_b);
    bus.op       = 3'(op);
    bus.acc_mode = acc;
    bus.btn_exec = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.btn_exec = 1'b0;
    if (poke_a) bus.btn_a = 1'b1;
    lat    = 0;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (poke_b && k == 2) bus.btn_b = 1'b1;
      if (poke_b && k == 3) bus.btn_b = 1'b0;
      if (poke_a && k == 2) bus.btn_a = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, (op == 7) ? W + 2 : 2);
    chk("busy_cycles", busy_n, (op == 7) ? W + 1 : 1);
    if (acc) model_a = int'(e.res % M);
    chk("exec_a_q", bus.a_q, model_a);
    chk("exec_b_q", bus.b_q, model_b);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    rstn         = 1'b0;
    bus.btn_a    = 1'b1;
    bus.btn_b    = 1'b0;
    bus.btn_exec = 1'b0;
    bus.dir      = 1'b0;
    bus.op       = 3'd0;
    bus.acc_mode = 1'b0;

    // Reset with btn_a held: one press after release.
    repeat (2) @(negedge clk);
    chk("rst_a_q", bus.a_q, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_busy", bus.busy, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_a_q", bus.a_q, 1);
    chk("rel_b_q", bus.b_q, 0);
    chk("rel_carry", bus.carry, 0);
    chk("rel_ovf", bus.ovf, 0);
    chk("rel_zero", bus.zero, 1);
    chk("rel_valid", bus.valid, 0);
    bus.btn_a = 1'b0;
    model_a = 1;
    @(posedge clk); #1;

    // Wrap-around and simultaneous stepping.
    set_ab(0, 0);
    step(1, 0, 1);
    chk("wrap_down", bus.a_q, M - 1);
    step(1, 0, 0);
    chk("wrap_up", bus.a_q, 0);
    step(1, 1, 0);

    // Directed arithmetic and flag corners.
    set_ab(9, 8);   do_exec(0, 0, 0, 0);
    set_ab(3, 5);   do_exec(1, 0, 0, 0);
    set_ab(5, 5);   do_exec(1, 0, 0, 0);
    set_ab(15, 15); do_exec(7, 0, 1, 0);
    set_ab(1, 4);   do_exec(5, 0, 0, 0);
    set_ab(8, 3);   do_exec(6, 0, 0, 0);

    // Accumulator chain, then a btn_a press landing in the DONE cycle.
    set_ab(2, 3);
    repeat (3) do_exec(0, 1, 0, 0);
    chk("acc_chain", bus.a_q, 11);
    do_exec(0, 1, 0, 1);
    chk("acc_vs_step", bus.a_q, 14);

    // Reset during the second multiply cycle aborts without completion.
    set_ab(5, 6);
    bus.op       = 3'd7;
    bus.acc_mode = 1'b0;
    bus.btn_exec = 1'b1;
    @(posedge clk); #1;
    bus.btn_exec = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    seen = 0;
    @(negedge clk);
    if (bus.valid) seen++;
    chk("abort_res", bus.res, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_a_q", bus.a_q, 0);
    rstn = 1'b1;
    sb.delete();
    repeat (8) begin
      @(negedge clk);
      if (bus.valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    model_a = 0;
    model_b = 0;
    @(posedge clk); #1;

    // Randomised operations.
    for (int i = 0; i < 30; i++) begin
      int ra, rb, rop;
      bit racc;
      ra   = $urandom_range(0, M - 1);
      rb   = $urandom_range(0, M - 1);
      rop  = $urandom_range(0, 7);
      racc = 1'($urandom_range(0, 1));
      set_ab(ra, rb);
      do_exec(rop, racc, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
